// File: rtl/fc_loss.sv
// fc_loss: output-error stage behind the fc layer. It collects one sample of
// class scores, streams back e[i] = y[i] - onehot(label)[i] in index order,
// and keeps an argmax prediction plus saturating sample/correct counters.
module fc_loss #(
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 10,
  parameter int FRAC_BITS   = 16,
  parameter int ERR_SHIFT   = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_rdy,
  input  logic [31:0]          in_data,
  input  logic [IDX_WIDTH-1:0] in_idx,
  input  logic                 label_valid,
  output logic                 label_rdy,
  input  logic [IDX_WIDTH-1:0] label,
  output logic                 out_valid,
  input  logic                 out_rdy,
  output logic [31:0]          out_data,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic [IDX_WIDTH-1:0] pred,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] sample_cnt,
  output logic [CNT_WIDTH-1:0] correct_cnt
);

  localparam int AW = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDX_WIDTH:0]     NC         = (IDX_WIDTH+1)'(NUM_CLASSES);
  localparam logic [IDX_WIDTH-1:0]   LAST_IDX   = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic signed [31:0]     TARGET_ONE = 32'sd1 <<< FRAC_BITS;

  typedef enum logic [1:0] {LABEL, COLLECT, SEND} state_t;

  state_t                    state, state_next;
  logic [IDX_WIDTH-1:0]      label_q;
  logic [NUM_CLASSES-1:0]    mask_q, mask_set;
  logic signed [31:0]        yv_q [NUM_CLASSES];
  logic                      primed;
  logic signed [31:0]        best_val;
  logic [IDX_WIDTH-1:0]      best_idx;

  logic                      idx_ok;
  logic                      out_acc;
  logic                      last_acc;
  logic [IDX_WIDTH-1:0]      load_idx;
  logic signed [31:0]        load_y;
  logic signed [31:0]        cur_y;
  logic signed [31:0]        err_p0;
  logic                      better;
  logic [IDX_WIDTH-1:0]      arg_idx;

  // Clamp a 33-bit difference into the signed 32-bit range.
  function automatic logic signed [31:0] sat32(input logic signed [32:0] v);
    if (v[32] != v[31]) return v[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    return $signed(v[31:0]);
  endfunction

  // Error for one class: saturated y - target, then arithmetic scaling.
  function automatic logic signed [31:0] error_of(input logic signed [31:0] y,
                                                  input logic is_tgt);
    logic signed [31:0] tgt;
    logic signed [32:0] diff;
    tgt  = is_tgt ? TARGET_ONE : 32'sd0;
    diff = {y[31], y} - {tgt[31], tgt};
    return sat32(diff) >>> ERR_SHIFT;
  endfunction

  // Datapath decode: collect mask update, next error beat, running argmax.
  always_comb begin
    idx_ok   = ({1'b0, in_idx} < NC);
    mask_set = mask_q;
    if (idx_ok) mask_set[in_idx[AW-1:0]] = 1'b1;
    out_acc  = out_valid && out_rdy;
    last_acc = out_acc && (out_idx == LAST_IDX);
    load_idx = out_valid ? out_idx + 1'b1 : '0;
    load_y   = yv_q[load_idx[AW-1:0]];
    err_p0   = error_of(load_y, label_q == load_idx);
    cur_y    = yv_q[out_idx[AW-1:0]];
    better   = (out_idx == '0) || (cur_y > best_val);
    arg_idx  = better ? out_idx : best_idx;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LABEL;
    else     state <= state_next;
  end

  // Next-state and handshake-ready decode.
  always_comb begin
    state_next = state;
    in_rdy     = 1'b0;
    label_rdy  = 1'b0;
    case (state)
      LABEL: begin
        label_rdy = 1'b1;
        if (label_valid) state_next = COLLECT;
      end
      COLLECT: begin
        in_rdy = 1'b1;
        if (in_valid && (&mask_set)) state_next = SEND;
      end
      SEND: begin
        if (last_acc) state_next = LABEL;
      end
      default: state_next = LABEL;
    endcase
  end

  // Control and output registers: mask, turnaround, beat sequencing, stats.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q      <= '0;
      primed      <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      pred        <= '0;
      done        <= 1'b0;
      sample_cnt  <= '0;
      correct_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        COLLECT: begin
          if (in_valid && idx_ok) mask_q <= mask_set;
        end
        SEND: begin
          if (!primed) begin
            primed <= 1'b1;
          end else if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= err_p0;
            out_idx   <= load_idx;
          end else if (out_rdy) begin
            if (out_idx == LAST_IDX) begin
              out_valid <= 1'b0;
              pred      <= arg_idx;
              done      <= 1'b1;
              mask_q    <= '0;
              primed    <= 1'b0;
              if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
              if ((arg_idx == label_q) && (correct_cnt != '1))
                correct_cnt <= correct_cnt + 1'b1;
            end else begin
              out_data <= err_p0;
              out_idx  <= load_idx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data storage: label, class scores and argmax tracker (no reset needed).
  always_ff @(posedge clk) begin
    if (label_valid && label_rdy) label_q <= label;
    if (in_valid && in_rdy && idx_ok) yv_q[in_idx[AW-1:0]] <= $signed(in_data);
    if (out_acc) begin
      if (better) best_val <= cur_y;
      best_idx <= arg_idx;
    end
  end

endmodule

// File: tb/tb_fc_loss.sv
// Directed bench for fc_loss with default parameters.
module tb_fc_loss;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_rdy;
  logic [31:0] in_data;
  logic [9:0]  in_idx;
  logic        label_valid, label_rdy;
  logic [9:0]  label;
  logic        out_valid, out_rdy;
  logic [31:0] out_data;
  logic [9:0]  out_idx, pred;
  logic        done;
  logic [15:0] sample_cnt, correct_cnt;

  int total = 0;
  int passed = 0;
  int ng, first_valid, ndone, held_bad;
  logic timed_out;
  logic [9:0]  got_idx  [32];
  logic [31:0] got_data [32];

  fc_loss dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_rdy(in_rdy), .in_data(in_data), .in_idx(in_idx),
    .label_valid(label_valid), .label_rdy(label_rdy), .label(label),
    .out_valid(out_valid), .out_rdy(out_rdy), .out_data(out_data), .out_idx(out_idx),
    .pred(pred), .done(done), .sample_cnt(sample_cnt), .correct_cnt(correct_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_label(input logic [9:0] l);
    logic ok;
    ok = 1'b0;
    label_valid = 1'b1; label = l;
    for (int k = 0; k < 50; k++) begin
      if (label_rdy) begin ok = 1'b1; @(negedge clk); break; end
      @(negedge clk);
    end
    label_valid = 1'b0;
    total++;
    if (!ok) $display("FAIL label_handshake got timeout want accept");
    else passed++;
  endtask

  task automatic send_beat(input logic [9:0] idx, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_idx = idx; in_data = d;
    for (int k = 0; k < 50; k++) begin
      if (in_rdy) begin ok = 1'b1; @(negedge clk); break; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL beat_handshake idx %0d got timeout want accept", idx);
    end
  endtask

  // Drain one sample's error stream, optionally holding out_rdy low.
  task automatic run_send(input int stall_at, input int stall_len);
    int stall_left, done_c;
    logic stalled;
    logic [9:0]  snap_i;
    logic [31:0] snap_d;
    ng = 0; first_valid = -1; ndone = 0; held_bad = 0; timed_out = 1'b1;
    stall_left = stall_len; stalled = 1'b0; done_c = -1;
    snap_i = '0; snap_d = '0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (done) begin ndone++; if (done_c < 0) done_c = c; end
      if (done_c >= 0 && c >= done_c + 3) begin timed_out = 1'b0; break; end
      if (out_valid && first_valid < 0) first_valid = c;
      if (out_valid && ng == stall_at && stall_left > 0) begin
        if (!stalled) begin stalled = 1'b1; snap_i = out_idx; snap_d = out_data; end
        else if (out_idx !== snap_i || out_data !== snap_d) held_bad++;
        out_rdy = 1'b0;
        stall_left--;
      end else begin
        if (stalled && (!out_valid || out_idx !== snap_i || out_data !== snap_d)) held_bad++;
        stalled = 1'b0;
        out_rdy = 1'b1;
        if (out_valid && ng < 32) begin
          got_idx[ng] = out_idx; got_data[ng] = out_data; ng++;
        end
      end
    end
    out_rdy = 1'b1;
    total++;
    if (timed_out) $display("FAIL send_timeout got no done want done");
    else passed++;
  endtask

  task automatic check_stream(input string name, input logic [31:0] exp_d [10]);
    total++;
    if (ng !== 10) $display("FAIL %s_beat_count got %0d want 10", name, ng);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (got_idx[i] !== 10'(i)) $display("FAIL %s_idx[%0d] got %0d want %0d", name, i, got_idx[i], i);
      else passed++;
      total++;
      if (got_data[i] !== exp_d[i]) $display("FAIL %s_data[%0d] got %h want %h", name, i, got_data[i], exp_d[i]);
      else passed++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL rst_out_data got %h want 0", out_data); else passed++;
    total++; if (out_idx !== 10'd0) $display("FAIL rst_out_idx got %0d want 0", out_idx); else passed++;
    total++; if (pred !== 10'd0) $display("FAIL rst_pred got %0d want 0", pred); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else passed++;
    total++; if (sample_cnt !== 16'd0) $display("FAIL rst_sample_cnt got %0d want 0", sample_cnt); else passed++;
    total++; if (correct_cnt !== 16'd0) $display("FAIL rst_correct_cnt got %0d want 0", correct_cnt); else passed++;
    total++; if (label_rdy !== 1'b1) $display("FAIL rst_label_rdy got %b want 1", label_rdy); else passed++;
    total++; if (in_rdy !== 1'b0) $display("FAIL rst_in_rdy got %b want 0", in_rdy); else passed++;
  endtask

  task automatic test_basic;
    logic [31:0] exp_d [10];
    send_label(10'd3);
    total++; if (label_rdy !== 1'b0) $display("FAIL basic_label_rdy got %b want 0", label_rdy); else passed++;
    for (int i = 0; i < 10; i++) send_beat(10'(i), (i == 3) ? 32'h0001_0000 : 32'h0);
    run_send(-1, 0);
    for (int i = 0; i < 10; i++) exp_d[i] = 32'h0;
    check_stream("basic", exp_d);
    total++; if (first_valid !== 2) $display("FAIL basic_latency got %0d want 2", first_valid); else passed++;
    total++; if (ndone !== 1) $display("FAIL basic_done_pulses got %0d want 1", ndone); else passed++;
    total++; if (pred !== 10'd3) $display("FAIL basic_pred got %0d want 3", pred); else passed++;
    total++; if (sample_cnt !== 16'd1) $display("FAIL basic_sample_cnt got %0d want 1", sample_cnt); else passed++;
    total++; if (correct_cnt !== 16'd1) $display("FAIL basic_correct_cnt got %0d want 1", correct_cnt); else passed++;
  endtask

  task automatic test_reverse;
    logic [31:0] exp_d [10];
    send_label(10'd0);
    for (int i = 9; i >= 0; i--) send_beat(10'(i), (i == 0) ? 32'h0000_8000 : 32'h0);
    run_send(-1, 0);
    for (int i = 0; i < 10; i++) exp_d[i] = 32'h0;
    exp_d[0] = 32'hFFFF_8000;
    check_stream("reverse", exp_d);
    total++; if (first_valid !== 2) $display("FAIL reverse_latency got %0d want 2", first_valid); else passed++;
    total++; if (pred !== 10'd0) $display("FAIL reverse_pred got %0d want 0", pred); else passed++;
    total++; if (correct_cnt !== 16'd2) $display("FAIL reverse_correct_cnt got %0d want 2", correct_cnt); else passed++;
  endtask

  task automatic test_stall;
    logic [31:0] exp_d [10];
    send_label(10'd7);
    for (int i = 0; i < 10; i++) send_beat(10'(i), 32'(i) * 32'h1000);
    run_send(4, 5);
    for (int i = 0; i < 10; i++) exp_d[i] = 32'(i) * 32'h1000;
    exp_d[7] = 32'hFFFF_7000;
    check_stream("stall", exp_d);
    total++; if (held_bad !== 0) $display("FAIL stall_hold got %0d changes want 0", held_bad); else passed++;
    total++; if (pred !== 10'd9) $display("FAIL stall_pred got %0d want 9", pred); else passed++;
    total++; if (sample_cnt !== 16'd3) $display("FAIL stall_sample_cnt got %0d want 3", sample_cnt); else passed++;
    total++; if (correct_cnt !== 16'd2) $display("FAIL stall_correct_cnt got %0d want 2", correct_cnt); else passed++;
  endtask

  task automatic test_tie;
    logic [31:0] exp_d [10];
    send_label(10'd5);
    for (int i = 0; i < 10; i++) send_beat(10'(i), (i == 2 || i == 5) ? 32'h0002_0000 : 32'h0);
    run_send(-1, 0);
    for (int i = 0; i < 10; i++) exp_d[i] = 32'h0;
    exp_d[2] = 32'h0002_0000;
    exp_d[5] = 32'h0001_0000;
    check_stream("tie", exp_d);
    total++; if (pred !== 10'd2) $display("FAIL tie_pred got %0d want 2", pred); else passed++;
    total++; if (sample_cnt !== 16'd4) $display("FAIL tie_sample_cnt got %0d want 4", sample_cnt); else passed++;
    total++; if (correct_cnt !== 16'd2) $display("FAIL tie_correct_cnt got %0d want 2", correct_cnt); else passed++;
  endtask

  task automatic test_saturate;
    logic [31:0] exp_d [10];
    send_label(10'd1);
    send_beat(10'd0, 32'h0000_0005);
    send_beat(10'd12, 32'h1234_5678);
    for (int i = 2; i < 10; i++) send_beat(10'(i), 32'h0);
    send_beat(10'd0, 32'h0000_0001);
    repeat (3) @(negedge clk);
    total++; if (in_rdy !== 1'b1) $display("FAIL sat_still_collect got in_rdy %b want 1", in_rdy); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL sat_no_early_send got %b want 0", out_valid); else passed++;
    send_beat(10'd1, 32'h8000_0000);
    run_send(-1, 0);
    for (int i = 0; i < 10; i++) exp_d[i] = 32'h0;
    exp_d[0] = 32'h0000_0001;
    exp_d[1] = 32'h8000_0000;
    check_stream("sat", exp_d);
    total++; if (pred !== 10'd0) $display("FAIL sat_pred got %0d want 0", pred); else passed++;
    total++; if (sample_cnt !== 16'd5) $display("FAIL sat_sample_cnt got %0d want 5", sample_cnt); else passed++;
    total++; if (correct_cnt !== 16'd2) $display("FAIL sat_correct_cnt got %0d want 2", correct_cnt); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp_d [10];
    logic seen;
    send_label(10'd2);
    for (int i = 0; i < 10; i++) send_beat(10'(i), 32'h0);
    out_rdy = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && out_idx == 10'd4) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!seen) $display("FAIL mid_reach_idx4 got no beat 4 want beat 4"); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", out_valid); else passed++;
    total++; if (label_rdy !== 1'b1) $display("FAIL mid_label_state got %b want 1", label_rdy); else passed++;
    total++; if (sample_cnt !== 16'd0) $display("FAIL mid_sample_cnt got %0d want 0", sample_cnt); else passed++;
    total++; if (correct_cnt !== 16'd0) $display("FAIL mid_correct_cnt got %0d want 0", correct_cnt); else passed++;
    total++; if (done !== 1'b0) $display("FAIL mid_done got %b want 0", done); else passed++;
    send_label(10'd4);
    for (int i = 0; i < 9; i++) send_beat(10'(i), 32'h0);
    repeat (2) @(negedge clk);
    total++; if (in_rdy !== 1'b1) $display("FAIL mid_mask_cleared got in_rdy %b want 1", in_rdy); else passed++;
    send_beat(10'd9, 32'h0);
    run_send(-1, 0);
    total++; if (pred !== 10'd0) $display("FAIL mid_pred_allzero got %0d want 0", pred); else passed++;
    send_label(10'd4);
    for (int i = 0; i < 10; i++) send_beat(10'(i), (i == 4) ? 32'h0003_0000 : 32'h0);
    run_send(-1, 0);
    for (int i = 0; i < 10; i++) exp_d[i] = 32'h0;
    exp_d[4] = 32'h0002_0000;
    check_stream("mid", exp_d);
    total++; if (pred !== 10'd4) $display("FAIL mid_pred got %0d want 4", pred); else passed++;
    total++; if (sample_cnt !== 16'd2) $display("FAIL mid_sample_cnt_after got %0d want 2", sample_cnt); else passed++;
    total++; if (correct_cnt !== 16'd1) $display("FAIL mid_correct_cnt_after got %0d want 1", correct_cnt); else passed++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_idx = '0;
    label_valid = 1'b0; label = '0; out_rdy = 1'b1;
    test_reset;
    test_basic;
    test_reverse;
    test_stall;
    test_tie;
    test_saturate;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
